// File: rtl/dbus_write_buffer.sv
// Posted-write buffer: DEPTH-entry FIFO of {addr, data} between the CPU store bus and a req/ack memory port.
// Optional macro DBUS_WB_COALESCE_EN merges a store into the tail-most entry when the address matches.
module dbus_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              data_addr,
    input  logic [31:0]              data_out,
    input  logic                     data_write,
    output logic                     stall,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          overflow_q;
    logic          push;
    logic          pop;
    logic          coalesce;

`ifdef DBUS_WB_COALESCE_EN
    logic [PW-1:0] last;
    assign last = tail - PW'(1);
    // With only one entry the tail-most entry is the head being presented, so it must not change.
    assign coalesce = data_write && (count_q >= CW'(2)) && (addr_mem[last] == data_addr);
`else
    assign coalesce = 1'b0;
`endif

    assign stall     = (count_q == FULL);
    assign mem_req   = (count_q != '0);
    assign mem_addr  = addr_mem[head];
    assign mem_wdata = data_mem[head];
    assign count     = count_q;
    assign overflow  = overflow_q;

    assign push = data_write && !stall && !coalesce;
    assign pop  = mem_req && mem_ack;

    always_comb begin
        count_nxt = count_q;
        unique case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_nxt;
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            if (data_write && stall && !coalesce) overflow_q <= 1'b1;
        end
    end

    // Entry storage is intentionally not reset; contents are ignored while mem_req is low.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= data_addr;
            data_mem[tail] <= data_out;
        end
`ifdef DBUS_WB_COALESCE_EN
        else if (coalesce) begin
            data_mem[last] <= data_out;
        end
`endif
    end

endmodule

// File: tb/tb_dbus_write_buffer.sv
// Directed bench for dbus_write_buffer (DEPTH=4): vector table plus hand-written
// sequences for streaming with a tied-high ack and for asynchronous reset mid-request.
module tb_dbus_write_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic        data_write;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [2:0]  count;
    logic        overflow;

    int n_vec  = 0;
    int n_miss = 0;

    dbus_write_buffer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_addr  (data_addr),
        .data_out   (data_out),
        .data_write (data_write),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ack;
        int          cnt;
        logic        stl;
        logic        req;
        logic        ov;
        logic        chk_head;
        logic [31:0] haddr;
        logic [31:0] hdata;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic we, input logic [31:0] a, input logic [31:0] d, input logic ack,
                       input int cnt, input logic stl, input logic ov,
                       input logic ch, input logic [31:0] ha, input logic [31:0] hd);
        vec_t v;
        v.we = we; v.addr = a; v.data = d; v.ack = ack;
        v.cnt = cnt; v.stl = stl; v.req = (cnt != 0); v.ov = ov;
        v.chk_head = ch; v.haddr = ha; v.hdata = hd;
        vt.push_back(v);
    endtask

    logic [31:0] exp_q[$];
    int          popped;

    initial begin
        rst_n = 1'b0; data_write = 1'b0; data_addr = '0; data_out = '0; mem_ack = 1'b0;

        // single store, held, then acked
        add(1, 32'h100, 32'hAAAA0001, 0, 1, 0, 0, 1, 32'h100, 32'hAAAA0001);
        add(0, 0, 0, 0, 1, 0, 0, 1, 32'h100, 32'hAAAA0001);
        add(0, 0, 0, 0, 1, 0, 0, 1, 32'h100, 32'hAAAA0001);
        add(0, 0, 0, 0, 1, 0, 0, 1, 32'h100, 32'hAAAA0001);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // fill to full, drop fifth, then drain; a store with the first pop is still dropped
        add(1, 32'h0,  32'h10, 0, 1, 0, 0, 1, 32'h0, 32'h10);
        add(1, 32'h4,  32'h11, 0, 2, 0, 0, 1, 32'h0, 32'h10);
        add(1, 32'h8,  32'h12, 0, 3, 0, 0, 1, 32'h0, 32'h10);
        add(1, 32'hC,  32'h13, 0, 4, 1, 0, 1, 32'h0, 32'h10);
        add(1, 32'h10, 32'h14, 0, 4, 1, 1, 1, 32'h0, 32'h10);
        add(1, 32'h50, 32'h99, 1, 3, 0, 1, 1, 32'h4, 32'h11);
        add(0, 0, 0, 1, 2, 0, 1, 1, 32'h8, 32'h12);
        add(0, 0, 0, 1, 1, 0, 1, 1, 32'hC, 32'h13);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        // simultaneous accept and pop at count==1; ack on empty ignored
        add(1, 32'h1C, 32'h4, 0, 1, 0, 1, 1, 32'h1C, 32'h4);
        add(1, 32'h20, 32'h5, 1, 1, 0, 1, 1, 32'h20, 32'h5);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        // same-address stores: merged only when the coalesce feature is built in
        add(1, 32'h0, 32'h1, 0, 1, 0, 1, 1, 32'h0, 32'h1);
        add(1, 32'h8, 32'h2, 0, 2, 0, 1, 1, 32'h0, 32'h1);
`ifdef DBUS_WB_COALESCE_EN
        add(1, 32'h8, 32'h3, 0, 2, 0, 1, 1, 32'h0, 32'h1);
        add(0, 0, 0, 1, 1, 0, 1, 1, 32'h8, 32'h3);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
`else
        add(1, 32'h8, 32'h3, 0, 3, 0, 1, 1, 32'h0, 32'h1);
        add(0, 0, 0, 1, 2, 0, 1, 1, 32'h8, 32'h2);
        add(0, 0, 0, 1, 1, 0, 1, 1, 32'h8, 32'h3);
`endif
        add(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("reset_count",    32'(count),    0);
        chk("reset_stall",    32'(stall),    0);
        chk("reset_mem_req",  32'(mem_req),  0);
        chk("reset_overflow", 32'(overflow), 0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            @(negedge clk);
            data_write = vt[i].we; data_addr = vt[i].addr; data_out = vt[i].data; mem_ack = vt[i].ack;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", i),    32'(count),    32'(vt[i].cnt));
            chk($sformatf("v%0d_stall", i),    32'(stall),    32'(vt[i].stl));
            chk($sformatf("v%0d_mem_req", i),  32'(mem_req),  32'(vt[i].req));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vt[i].ov));
            if (vt[i].chk_head) begin
                chk($sformatf("v%0d_mem_addr", i),  mem_addr,  vt[i].haddr);
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vt[i].hdata);
            end
        end

        // streaming stores with mem_ack tied high
        @(negedge clk);
        data_write = 1'b0; mem_ack = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 16; k++) exp_q.push_back(32'(k * 4));
        popped = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            chk("stream_stall", 32'(stall), 0);
            chk("stream_count_le2", 32'(count <= 3'd2), 1);
            if (mem_req) begin
                if (popped < 16) chk("stream_order", mem_addr, exp_q[popped]);
                else chk("stream_extra_pop", mem_addr, 32'hFFFF_FFFF);
                popped++;
            end
            if (cyc < 16) begin
                data_write = 1'b1; data_addr = 32'(cyc * 4); data_out = 32'(cyc);
            end else begin
                data_write = 1'b0;
            end
        end
        chk("stream_pops", 32'(popped), 16);

        // asynchronous reset with three entries queued
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_write = 1'b1; data_addr = 32'h200 + 32'(k); data_out = 32'(k);
            @(negedge clk);
        end
        data_write = 1'b0;
        chk("pre_rst_count", 32'(count), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req",  32'(mem_req),  0);
        chk("async_rst_count",    32'(count),    0);
        chk("async_rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        data_write = 1'b1; data_addr = 32'h40; data_out = 32'h77;
        @(posedge clk);
        #1;
        chk("post_rst_count",    32'(count),   1);
        chk("post_rst_mem_req",  32'(mem_req), 1);
        chk("post_rst_mem_addr", mem_addr,     32'h40);
        chk("post_rst_wdata",    mem_wdata,    32'h77);
        @(negedge clk);
        data_write = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
